// File: rtl/ps2_arrow_decoder_if.sv
// ps2_arrow_decoder_if
//   Byte stream from the PS/2 receiver into the arrow decoder, plus the decoded
//   direction/status outputs going out to the game logic.
//   master : byte source / output consumer (receiver side, testbench)
//   slave  : the decoder
//   byte_in[7:0], byte_valid          : scan-code byte and its one-cycle strobe
//   up, down, left, right             : held arrow state
//   any_dir, press_pulse, seq_error   : registered summary, rise pulse, sticky abort flag
interface ps2_arrow_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       any_dir;
  logic       press_pulse;
  logic       seq_error;

  modport master (
    output byte_in, byte_valid,
    input  up, down, left, right, any_dir, press_pulse, seq_error
  );

  modport slave (
    input  byte_in, byte_valid,
    output up, down, left, right, any_dir, press_pulse, seq_error
  );
endinterface

// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
//   PS/2 set-2 scan-code decoder. Consumes one byte per byte_valid strobe, tracks
//   E0 / F0 / E1 prefix sequences and keeps held state for the four arrow keys.
//   Ports:
//     clk   : system clock
//     rst   : synchronous, active-high reset
//     bus   : ps2_arrow_decoder_if.slave (byte stream in, direction/status out)
//   Parameters:
//     TIMEOUT_CYCLES : idle cycles tolerated inside a prefix sequence before abort
//     CNT_W          : timeout counter width, must hold TIMEOUT_CYCLES
//   Build option:
//     WASD_EN : when defined, non-extended W/S/A/D alias up/down/left/right, held in
//               separate per-key bits so an alias release never drops a held arrow.

// One key lane: arrow held bit, plus the WASD alias bit when enabled.
module ps2_key_lane (
  input  logic clk,
  input  logic rst,
  input  logic arrow_set,
  input  logic arrow_clr,
`ifdef WASD_EN
  input  logic wasd_set,
  input  logic wasd_clr,
`endif
  output logic held
);
  logic arrow_q;

  always_ff @(posedge clk) begin
    if (rst)            arrow_q <= 1'b0;
    else if (arrow_set) arrow_q <= 1'b1;
    else if (arrow_clr) arrow_q <= 1'b0;
  end

`ifdef WASD_EN
  logic wasd_q;

  always_ff @(posedge clk) begin
    if (rst)           wasd_q <= 1'b0;
    else if (wasd_set) wasd_q <= 1'b1;
    else if (wasd_clr) wasd_q <= 1'b0;
  end

  assign held = arrow_q | wasd_q;
`else
  assign held = arrow_q;
`endif
endmodule

module ps2_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_arrow_decoder_if.slave    bus
);
  localparam int NUM_KEYS = 4;  // lane order: up, down, left, right

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            skip_q, skip_d;
  logic                  err_q, err_d;

  logic [NUM_KEYS-1:0]   arrow_set, arrow_clr;
  logic [NUM_KEYS-1:0]   held, held_prev;
  logic                  any_q, pulse_q;

  function automatic logic [NUM_KEYS-1:0] arrow_onehot(input logic [7:0] b);
    case (b)
      8'h75:   arrow_onehot = 4'b0001;
      8'h72:   arrow_onehot = 4'b0010;
      8'h6B:   arrow_onehot = 4'b0100;
      8'h74:   arrow_onehot = 4'b1000;
      default: arrow_onehot = 4'b0000;
    endcase
  endfunction

`ifdef WASD_EN
  logic [NUM_KEYS-1:0] wasd_set, wasd_clr;

  function automatic logic [NUM_KEYS-1:0] wasd_onehot(input logic [7:0] b);
    case (b)
      8'h1D:   wasd_onehot = 4'b0001;
      8'h1B:   wasd_onehot = 4'b0010;
      8'h1C:   wasd_onehot = 4'b0100;
      8'h23:   wasd_onehot = 4'b1000;
      default: wasd_onehot = 4'b0000;
    endcase
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      skip_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    err_d     = err_q;
    arrow_set = '0;
    arrow_clr = '0;
`ifdef WASD_EN
    wasd_set  = '0;
    wasd_clr  = '0;
`endif

    // Timeout only ticks between strobes while a sequence is open; a strobe
    // landing on the expiry cycle takes priority and is decoded normally.
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!bus.byte_valid) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        skip_d  = '0;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (bus.byte_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          case (bus.byte_in)
            B_E0: state_d = EXT;
            B_F0: state_d = BRK;
            B_E1: begin
              state_d = SKIP;
              skip_d  = 3'd7;  // rest of the 8-byte Pause make
            end
            default: begin
`ifdef WASD_EN
              wasd_set = wasd_onehot(bus.byte_in);
`endif
            end
          endcase
        end
        EXT: begin
          if (bus.byte_in == B_F0) begin
            state_d = EXT_BRK;
          end else begin
            arrow_set = arrow_onehot(bus.byte_in);
            state_d   = IDLE;
          end
        end
        EXT_BRK: begin
          arrow_clr = arrow_onehot(bus.byte_in);
          state_d   = IDLE;
        end
        BRK: begin
`ifdef WASD_EN
          wasd_clr = wasd_onehot(bus.byte_in);
`endif
          state_d  = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
    ps2_key_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .arrow_set (arrow_set[k]),
      .arrow_clr (arrow_clr[k]),
`ifdef WASD_EN
      .wasd_set  (wasd_set[k]),
      .wasd_clr  (wasd_clr[k]),
`endif
      .held      (held[k])
    );
  end

  // any_dir and press_pulse both trail the held vector by one cycle; held_prev
  // is the vector from before the latest update, so a rise is held & ~held_prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_prev <= '0;
      any_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      held_prev <= held;
      any_q     <= |held;
      pulse_q   <= |(held & ~held_prev);
    end
  end

  assign bus.up          = held[0];
  assign bus.down        = held[1];
  assign bus.left        = held[2];
  assign bus.right       = held[3];
  assign bus.any_dir     = any_q;
  assign bus.press_pulse = pulse_q;
  assign bus.seq_error   = err_q;
endmodule
